ds1302_ctrl: RTL and testbench
==============================

DS1302_CTRL -- requirements
Module: ds1302_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50, sysclk cycles per SCLK half-period (min 2).
REQ-002 SHALL have parameter DEPTH, default 8, data-buffer depth in bytes (1..31).
REQ-003 SHALL have parameter CE_WAIT, default 4, number of SCLK half-periods for CE setup, CE hold and CE-inactive recovery.
REQ-004 csi_clk  in  1  system clock, one clock domain; all logic on rising edge.
REQ-005 csi_reset_n  in  1  asynchronous active-low reset.
REQ-006 avs_s1_address  in  2  register select: 0 CMD, 1 LEN, 2 DATA, 3 STATUS.
REQ-007 avs_s1_read  in  1  Avalon read strobe.
REQ-008 avs_s1_write  in  1  Avalon write strobe.
REQ-009 avs_s1_writedata  in  8  write data.
REQ-010 avs_s1_readdata  out  8  read data, registered, read latency 1.
REQ-011 coe_clk  out  1  DS1302 SCLK.
REQ-012 coe_reset  out  1  DS1302 CE, active high.
REQ-013 coe_io  inout  1  DS1302 I/O; driven only while the output enable is set, else high-Z.

Function
REQ-014 Writing LEN SHALL store min(max(value,1),DEPTH).
REQ-015 Writing DATA SHALL push one byte into the buffer; a push when full SHALL be dropped and set err.
REQ-016 Reading DATA SHALL pop one byte; a pop when empty SHALL return 0x00 and set err.
REQ-017 Reading STATUS SHALL return {busy, done, err, level[4:0]} and clear done and err in the same cycle.
REQ-018 Writing CMD while idle SHALL start a transaction with that command byte; bit0=1 means read, bit0=0 means write.
REQ-019 A CMD write SHALL be ignored and set err if busy, if bit7=0, or if it is a write and level < LEN.
REQ-020 A read start SHALL flush the buffer.
REQ-021 FSM states: IDLE, SETUP, CMD, DATA, HOLD, RECOVER.
REQ-022 SETUP: CE=1, SCLK=0, for CE_WAIT half-periods; then go to CMD.
REQ-023 Each bit SHALL be a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles; transmission is LSB first.
REQ-024 CMD: 8 bits driven on coe_io, changing at the start of each low phase.
REQ-025 DATA write: LEN*8 bits popped from the buffer and driven the same way.
REQ-026 DATA read: io released at the falling edge ending CMD bit 7; each bit sampled on the last sysclk of its low phase; each completed byte is pushed into the buffer.
REQ-027 HOLD: SCLK=0, CE=1 for CE_WAIT half-periods, io released; then go to RECOVER.
REQ-028 RECOVER: CE=0 for CE_WAIT half-periods; then go to IDLE and set done.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 During a transaction, DATA pushes and pops SHALL be dropped and set err.
REQ-031 A Bus access in the same cycle as an internal push or pop SHALL give the internal operation priority.
REQ-032 LEN writes during busy SHALL take effect on the next transaction only.
REQ-033 The half-period counter SHALL wrap from CLK_DIV-1 to 0, and the bit counter SHALL wrap per byte.

Reset
REQ-034 On csi_reset_n low, immediately and asynchronously: coe_clk=0, coe_reset=0, io released, readdata=0x00, state IDLE, buffer empty, LEN=1, done=0, err=0.
REQ-035 A reset asserted mid-transaction SHALL abort it with no partial byte retained.

Structure
REQ-036 Package ds1302_pkg SHALL hold the register address constants, the FSM state enum and the STATUS bit positions.
REQ-037 Sub-module ds1302_fifo (parameter DEPTH, 8-bit, level output) SHALL implement the buffer.
REQ-038 The top level SHALL contain the FSM, the half-period counter, the bit counter, the shift register and the Avalon decode.

Verification (CLK_DIV=4, CE_WAIT=2, DEPTH=8; DS1302 behavioural model)
REQ-039 Write LEN=1, DATA=0x59, CMD=0x80 -> model receives cmd 0x80 then data 0x59 LSB first; SCLK period 8 cycles; STATUS then reads 0x40.
REQ-040 Model seconds=0x25; LEN=1, CMD=0x81 -> after done, DATA reads 0x25 and STATUS reads level 0.
REQ-041 Burst: LEN=8, CMD=0xBF with model clock bytes 0x00..0x07 -> 8 pops return 0x00..0x07 in order.
REQ-042 CMD=0x01 -> err set, no CE pulse; CMD during busy -> ignored, err set; 9th push with buffer full -> err set, level stays 8.
REQ-043 Reset asserted in DATA state -> coe_reset=0 and coe_clk=0 in the same cycle; post-reset STATUS reads 0x00.

Source files
------------

// File: rtl/ds1302_pkg.sv
// DS1302 controller shared definitions: register map, FSM states,
// STATUS bit positions and the LEN clamp helper.
package ds1302_pkg;

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_LEN    = 2'd1;
    localparam logic [1:0] ADDR_DATA   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int ST_BUSY = 7;
    localparam int ST_DONE = 6;
    localparam int ST_ERR  = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CMD,
        S_DATA,
        S_HOLD,
        S_RECOVER
    } state_e;

    // min(max(v,1),depth)
    function automatic logic [4:0] clamp_len(input logic [7:0] v,
                                             input int depth);
        if (v == 8'd0)
            return 5'd1;
        else if (int'(v) > depth)
            return 5'(depth);
        else
            return v[4:0];
    endfunction

endpackage

// File: rtl/ds1302_if.sv
// Avalon-MM slave bus bundle of the DS1302 controller.
// master: address/read/write/writedata out, readdata in; slave: mirror.
interface ds1302_if;

    logic [1:0] avs_s1_address;
    logic       avs_s1_read;
    logic       avs_s1_write;
    logic [7:0] avs_s1_writedata;
    logic [7:0] avs_s1_readdata;

    modport master (
        output avs_s1_address, avs_s1_read, avs_s1_write,
        output avs_s1_writedata,
        input  avs_s1_readdata
    );

    modport slave (
        input  avs_s1_address, avs_s1_read, avs_s1_write,
        input  avs_s1_writedata,
        output avs_s1_readdata
    );

endinterface

// File: rtl/ds1302_fifo.sv
// Byte FIFO of DEPTH entries with flush and occupancy level.
// Ports: clk_i, rst_ni, flush_i, push_i/wdata_i, pop_i/rdata_o (head), level_o, full_o, empty_o.
module ds1302_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic [4:0] level_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem_q [2**AW];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_o  = (cnt_q == 5'(DEPTH));
    assign empty_o = (cnt_q == 5'd0);
    assign level_o = cnt_q;
    assign rdata_o = mem_q[rp_q];
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wp_d = inc(wp_q);
            if (do_pop)  rp_d = inc(rp_q);
            cnt_d = cnt_q + 5'(do_push) - 5'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wp_q] <= wdata_i;
    end

endmodule

// File: rtl/ds1302_ctrl.sv
// DS1302 RTC serial controller with Avalon-MM register interface.
// Ports: csi_clk, csi_reset_n, avs (ds1302_if.slave), coe_clk (SCLK), coe_reset (CE), coe_io.
module ds1302_ctrl
    import ds1302_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int DEPTH   = 8,
    parameter int CE_WAIT = 4
) (
    input  logic    csi_clk,
    input  logic    csi_reset_n,
    ds1302_if.slave avs,
    output logic    coe_clk,
    output logic    coe_reset,
    inout  wire     coe_io
);

    localparam int HPW = $clog2(CLK_DIV);
    localparam int WW  = (CE_WAIT > 1) ? $clog2(CE_WAIT) : 1;

    state_e         state_q, state_d;
    logic [HPW-1:0] hp_q, hp_d;
    logic           phase_q, phase_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [2:0]     bit_q, bit_d;
    logic [4:0]     byte_q, byte_d;
    logic [7:0]     sh_q, sh_d;
    logic           rd_q, rd_d;
    logic [4:0]     len_q, len_d, run_q, run_d;
    logic           done_q, done_d, err_q, err_d;
    logic [7:0]     rdata_q, rdata_d;

    logic       busy, io_oe, io_in;
    logic       tick, wait_last, bit_end, last_byte, rx_mode, rx_smp;
    logic       wr_cmd, wr_len, wr_data, rd_data, rd_stat;
    logic       start, push_ok, pop_ok, int_push, int_pop, set_err;
    logic       f_push, f_pop, f_flush, f_full, f_empty;
    logic [7:0] f_wdata, f_rdata;
    logic [4:0] f_level;

    assign io_in     = coe_io;
    assign coe_io    = io_oe ? sh_q[0] : 1'bz;
    assign avs.avs_s1_readdata = rdata_q;

    assign tick      = (hp_q == HPW'(CLK_DIV - 1));
    assign wait_last = (wait_q == WW'(CE_WAIT - 1));
    assign bit_end   = tick && phase_q;
    assign last_byte = (byte_q == run_q - 5'd1);
    assign rx_mode   = (state_q == S_DATA) && rd_q;
    // read bits are sampled on the last sysclk of the low phase
    assign rx_smp    = rx_mode && !phase_q && tick;

    assign wr_cmd  = avs.avs_s1_write && avs.avs_s1_address == ADDR_CMD;
    assign wr_len  = avs.avs_s1_write && avs.avs_s1_address == ADDR_LEN;
    assign wr_data = avs.avs_s1_write && avs.avs_s1_address == ADDR_DATA;
    assign rd_data = avs.avs_s1_read && avs.avs_s1_address == ADDR_DATA;
    assign rd_stat = avs.avs_s1_read && avs.avs_s1_address == ADDR_STATUS;

    assign start   = wr_cmd && !busy && avs.avs_s1_writedata[7] &&
                     (avs.avs_s1_writedata[0] || f_level >= len_q);
    assign push_ok = wr_data && !busy && !f_full;
    assign pop_ok  = rd_data && !busy && !f_empty;
    assign set_err = (wr_cmd && !start) || (wr_data && !push_ok) ||
                     (rd_data && !pop_ok);

    // internal FIFO traffic only happens while busy, where bus traffic is refused
    assign int_push = rx_smp && bit_q == 3'd7;
    assign int_pop  = bit_end && bit_q == 3'd7 && !rd_q &&
                      (state_q == S_CMD || (state_q == S_DATA && !last_byte));

    assign f_push  = int_push || push_ok;
    assign f_wdata = int_push ? {io_in, sh_q[7:1]} : avs.avs_s1_writedata;
    assign f_pop   = int_pop || pop_ok;
    assign f_flush = start && avs.avs_s1_writedata[0];

    ds1302_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (csi_clk),
        .rst_ni  (csi_reset_n),
        .flush_i (f_flush),
        .push_i  (f_push),
        .wdata_i (f_wdata),
        .pop_i   (f_pop),
        .rdata_o (f_rdata),
        .level_o (f_level),
        .full_o  (f_full),
        .empty_o (f_empty)
    );

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) state_q <= S_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_SETUP;
            S_SETUP:   if (tick && wait_last) state_d = S_CMD;
            S_CMD:     if (bit_end && bit_q == 3'd7) state_d = S_DATA;
            S_DATA:    if (bit_end && bit_q == 3'd7 && last_byte) state_d = S_HOLD;
            S_HOLD:    if (tick && wait_last) state_d = S_RECOVER;
            S_RECOVER: if (tick && wait_last) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        coe_reset = state_q inside {S_SETUP, S_CMD, S_DATA, S_HOLD};
        coe_clk   = phase_q && (state_q inside {S_CMD, S_DATA});
        io_oe     = (state_q == S_CMD) || ((state_q == S_DATA) && !rd_q);
    end

    always_comb begin
        hp_d    = '0;
        phase_d = 1'b0;
        wait_d  = '0;
        bit_d   = bit_q;
        byte_d  = byte_q;
        sh_d    = sh_q;
        rd_d    = rd_q;
        len_d   = len_q;
        run_d   = run_q;
        rdata_d = rdata_q;
        if (busy)
            hp_d = tick ? '0 : hp_q + HPW'(1);
        if (state_q inside {S_CMD, S_DATA})
            phase_d = phase_q ^ tick;
        if (state_q inside {S_SETUP, S_HOLD, S_RECOVER})
            wait_d = !tick ? wait_q : (wait_last ? '0 : wait_q + WW'(1));
        if (bit_end) begin
            bit_d = bit_q + 3'd1;
            if (!rx_mode) sh_d = sh_q >> 1;
            if (state_q == S_DATA && bit_q == 3'd7) byte_d = byte_q + 5'd1;
        end
        if (int_pop) sh_d = f_rdata;
        if (rx_smp)  sh_d = {io_in, sh_q[7:1]};
        if (start) begin
            sh_d   = avs.avs_s1_writedata;
            rd_d   = avs.avs_s1_writedata[0];
            run_d  = len_q;
            bit_d  = 3'd0;
            byte_d = 5'd0;
        end
        if (wr_len) len_d = clamp_len(avs.avs_s1_writedata, DEPTH);
        done_d = (done_q && !rd_stat) ||
                 (state_q == S_RECOVER && tick && wait_last);
        err_d  = (err_q && !rd_stat) || set_err;
        if (avs.avs_s1_read) begin
            unique case (avs.avs_s1_address)
                ADDR_LEN:    rdata_d = {3'b000, len_q};
                ADDR_DATA:   rdata_d = pop_ok ? f_rdata : 8'h00;
                ADDR_STATUS: rdata_d = {busy, done_q, err_q, f_level};
                default:     rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            hp_q    <= '0;
            phase_q <= 1'b0;
            wait_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 5'd0;
            sh_q    <= 8'h00;
            rd_q    <= 1'b0;
            len_q   <= 5'd1;
            run_q   <= 5'd1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            hp_q    <= hp_d;
            phase_q <= phase_d;
            wait_q  <= wait_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            rd_q    <= rd_d;
            len_q   <= len_d;
            run_q   <= run_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ds1302_ctrl.sv
// Testbench for ds1302_ctrl with a bit-level DS1302 slave model
// and a queue-based model of the register/buffer behaviour.
module tb_ds1302_ctrl;
    import ds1302_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    wire  coe_clk, coe_reset, io;

    ds1302_if bus();

    ds1302_ctrl #(.CLK_DIV(4), .DEPTH(8), .CE_WAIT(2)) dut (
        .csi_clk     (clk),
        .csi_reset_n (rst_n),
        .avs         (bus),
        .coe_clk     (coe_clk),
        .coe_reset   (coe_reset),
        .coe_io      (io)
    );

    initial forever #5 clk = ~clk;

    // DS1302 slave model
    logic       m_oe = 1'b0;
    logic       m_bit = 1'b0;
    int         m_cnt = 0;
    int         m_ce = 0;
    logic       m_read = 1'b0;
    logic [7:0] m_sh = 8'h00;
    logic [7:0] m_rx[$];
    logic [7:0] m_tx[32];
    time        m_last = 0;
    time        m_period = 0;

    assign io = m_oe ? m_bit : 1'bz;

    always @(posedge coe_reset) begin
        m_cnt  = 0;
        m_read = 1'b0;
        m_ce++;
    end

    always @(negedge coe_reset) m_oe = 1'b0;

    always @(posedge coe_clk) begin
        if (coe_reset) begin
            m_period = $time - m_last;
            m_last   = $time;
            if (m_cnt < 8 || !m_read) begin
                m_sh = {io, m_sh[7:1]};
                if (m_cnt % 8 == 7) begin
                    m_rx.push_back(m_sh);
                    if (m_cnt == 7) m_read = m_sh[0];
                end
            end
            m_cnt++;
        end
    end

    always @(negedge coe_clk) begin
        if (coe_reset && m_read && m_cnt >= 8) begin
            int k;
            k = m_cnt - 8;
            if (k / 8 < 32) begin
                m_oe  = 1'b1;
                m_bit = m_tx[k/8][k%8];
            end else begin
                m_oe = 1'b0;
            end
        end
    end

    // register-level reference model
    logic [7:0] bq[$];
    logic [7:0] exp_rx[$];
    int         mlen = 1;
    int         mn = 1;
    logic       mrd = 1'b0;
    logic       mbusy = 1'b0;
    logic       mdone = 1'b0;
    logic       merr = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;

    function automatic logic [7:0] exp_st();
        return {mbusy, mdone, merr, 5'(bq.size())};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.avs_s1_address   = a;
        bus.avs_s1_writedata = d;
        bus.avs_s1_write     = 1'b1;
        @(negedge clk);
        bus.avs_s1_write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.avs_s1_address = a;
        bus.avs_s1_read    = 1'b1;
        @(negedge clk);
        bus.avs_s1_read    = 1'b0;
        d = bus.avs_s1_readdata;
    endtask

    task automatic st_read(input string tag);
        logic [7:0] d;
        rd(ADDR_STATUS, d);
        chk(tag, 32'(d), 32'(exp_st()));
        mdone = 1'b0;
        merr  = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        wr(ADDR_DATA, b);
        if (mbusy || bq.size() == 8) merr = 1'b1;
        else bq.push_back(b);
    endtask

    task automatic pop(input string tag);
        logic [7:0] d, e;
        rd(ADDR_DATA, d);
        if (mbusy || bq.size() == 0) begin
            e    = 8'h00;
            merr = 1'b1;
        end else begin
            e = bq.pop_front();
        end
        chk(tag, 32'(d), 32'(e));
    endtask

    task automatic setlen(input logic [7:0] v);
        wr(ADDR_LEN, v);
        mlen = (v == 0) ? 1 : ((v > 8) ? 8 : int'(v));
    endtask

    task automatic cmd(input logic [7:0] c);
        logic ok;
        ok = !mbusy && c[7] && (c[0] || bq.size() >= mlen);
        if (ok) m_rx.delete();
        wr(ADDR_CMD, c);
        if (!ok) begin
            merr = 1'b1;
        end else begin
            mbusy = 1'b1;
            mrd   = c[0];
            mn    = mlen;
            exp_rx.delete();
            exp_rx.push_back(c);
            if (c[0]) bq.delete();
            else for (int i = 0; i < mn; i++) exp_rx.push_back(bq.pop_front());
        end
    endtask

    task automatic wait_done(input string tag);
        logic [7:0] d;
        int polls;
        polls = 0;
        do begin
            rd(ADDR_STATUS, d);
            polls++;
        end while (d[7] && polls < 1000);
        mbusy = 1'b0;
        mdone = 1'b1;
        if (polls > 1) merr = 1'b0;
        if (mrd) for (int i = 0; i < mn; i++) bq.push_back(m_tx[i]);
        chk({tag, "_status"}, 32'(d), 32'(exp_st()));
        mdone = 1'b0;
        merr  = 1'b0;
        chk({tag, "_rxlen"}, m_rx.size(), exp_rx.size());
        for (int i = 0; i < exp_rx.size(); i++)
            chk($sformatf("%s_rx%0d", tag, i),
                (i < m_rx.size()) ? 32'(m_rx[i]) : 32'h100, 32'(exp_rx[i]));
    endtask

    initial begin
        logic [7:0] d;
        int ce0, n;
        bus.avs_s1_address   = 2'd0;
        bus.avs_s1_read      = 1'b0;
        bus.avs_s1_write     = 1'b0;
        bus.avs_s1_writedata = 8'h00;
        for (int i = 0; i < 32; i++) m_tx[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        chk("rst_readdata", 32'(bus.avs_s1_readdata), 32'h00);
        chk("rst_sclk", 32'(coe_clk), 32'h0);
        chk("rst_ce", 32'(coe_reset), 32'h0);
        rst_n = 1'b1;
        st_read("rst_status");
        rd(ADDR_LEN, d);
        chk("rst_len", 32'(d), 32'd1);

        // single byte write
        setlen(8'd1);
        push(8'h59);
        cmd(8'h80);
        wait_done("wr59");
        chk("sclk_period", 32'(m_period), 32'd80);

        // single byte read
        m_tx[0] = 8'h25;
        cmd(8'h81);
        wait_done("rd25");
        pop("rd25_data");
        st_read("rd25_level");

        // clock burst read
        for (int i = 0; i < 8; i++) m_tx[i] = 8'(i);
        setlen(8'd8);
        cmd(8'hBF);
        wait_done("burst");
        for (int i = 0; i < 8; i++) pop($sformatf("burst_pop%0d", i));
        st_read("burst_empty");

        // randomized writes and reads
        for (int t = 0; t < 3; t++) begin
            n = $urandom_range(1, 8);
            setlen(8'(n));
            for (int i = 0; i < n; i++) push(8'($urandom));
            cmd(8'h80 | (8'($urandom) & 8'h7E));
            wait_done($sformatf("rwr%0d", t));
            for (int i = 0; i < 32; i++) m_tx[i] = 8'($urandom);
            n = $urandom_range(1, 8);
            setlen(8'(n));
            cmd(8'h81 | (8'($urandom) & 8'h7E));
            wait_done($sformatf("rrd%0d", t));
            for (int i = 0; i < n; i++) pop($sformatf("rrd%0d_pop%0d", t, i));
        end

        // LEN clamping
        setlen(8'd0);
        rd(ADDR_LEN, d);
        chk("len_zero", 32'(d), 32'(mlen));
        setlen(8'd200);
        rd(ADDR_LEN, d);
        chk("len_big", 32'(d), 32'(mlen));

        // rejected commands
        ce0 = m_ce;
        cmd(8'h01);
        repeat (20) @(negedge clk);
        chk("bit7_no_ce", m_ce, ce0);
        st_read("bit7_err");
        setlen(8'd2);
        push(8'h33);
        cmd(8'h80);
        repeat (20) @(negedge clk);
        chk("short_no_ce", m_ce, ce0);
        st_read("short_err");
        pop("short_drain");

        // bus traffic during a transaction
        for (int i = 0; i < 32; i++) m_tx[i] = 8'($urandom);
        cmd(8'h85);
        cmd(8'h87);
        push(8'h11);
        pop("busy_pop");
        setlen(8'd3);
        st_read("busy_err");
        wait_done("busy_txn");
        for (int i = 0; i < 2; i++) pop($sformatf("busy_txn_pop%0d", i));
        for (int i = 0; i < 3; i++) push(8'($urandom));
        cmd(8'hC2);
        wait_done("len_next");

        // overflow and underflow
        for (int i = 0; i < 9; i++) push(8'($urandom));
        st_read("full_err");
        for (int i = 0; i < 8; i++) pop($sformatf("full_pop%0d", i));
        pop("empty_pop");
        st_read("empty_err");

        // reset during DATA
        setlen(8'd8);
        for (int i = 0; i < 8; i++) push(8'($urandom));
        cmd(8'h80);
        n = 0;
        while (m_cnt < 10 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("in_data_ce", 32'(coe_reset), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_ce", 32'(coe_reset), 32'h0);
        chk("abort_sclk", 32'(coe_clk), 32'h0);
        chk("abort_readdata", 32'(bus.avs_s1_readdata), 32'h00);
        bq.delete();
        mlen  = 1;
        mbusy = 1'b0;
        mdone = 1'b0;
        merr  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        st_read("post_rst_status");
        rd(ADDR_LEN, d);
        chk("post_rst_len", 32'(d), 32'(mlen));

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
